gmii_mac_tx: RTL



---
 rtl/eth_pkg.sv | 39 +++
 rtl/crc32_d8.sv | 25 ++
 rtl/gmii_mac_tx.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/eth_pkg.sv
// Shared Ethernet constants, transmit FSM encoding and the byte-wide CRC-32 step.
package eth_pkg;

    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hD5;
    localparam logic [31:0] CRC_POLY      = 32'h04C1_1DB7;
    localparam logic [31:0] CRC_INIT      = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hC704_DD7B;

    typedef enum logic [2:0] {
        StIdle,
        StPre,
        StSfd,
        StData,
        StPad,
        StFcs,
        StIfg
    } tx_state_e;

    function automatic logic [31:0] reflect32(input logic [31:0] v);
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < 32; i++) begin
            r[i] = v[31-i];
        end
        return r;
    endfunction

    // Ethernet sends LSB first, so the register runs in reflected form.
    function automatic logic [31:0] crc32_byte(input logic [31:0] crc, input logic [7:0] data);
        logic [31:0] c;
        c = crc ^ {24'h0, data};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ reflect32(CRC_POLY)) : (c >> 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc32_d8.sv
// Byte-per-cycle reflected CRC-32 register with synchronous init; shared by TX and RX paths.
module crc32_d8
    import eth_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        init_i,
    input  logic        en_i,
    input  logic [7:0]  data_i,
    output logic [31:0] crc_o
);

    logic [31:0] crc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || init_i) begin
            crc_q <= CRC_INIT;
        end else if (en_i) begin
            crc_q <= crc32_byte(crc_q, data_i);
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/gmii_mac_tx.sv
// GMII transmit framer: preamble, SFD, payload, optional pad, FCS and inter-frame gap.
// Define GMII_TX_PAD_EN to pad short frames with zeros up to MIN_DATA_BYTES.
module gmii_mac_tx
    import eth_pkg::*;
#(
    parameter int unsigned PREAMBLE_BYTES = 7,
    parameter int unsigned MIN_DATA_BYTES = 60,
    parameter int unsigned IFG_BYTES      = 12,
    parameter int unsigned CNT_W          = 11
) (
    input  logic       gmii_tx_clk,
    input  logic       rst,
    input  logic [7:0] s_data,
    input  logic       s_valid,
    input  logic       s_last,
    output logic       s_ready,
    output logic       gmii_tx_en,
    output logic [7:0] gmii_txd,
    output logic       tx_busy,
    output logic       frame_done,
    output logic       underrun
);

    tx_state_e        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_inc;
    logic             abort_q;
    logic [31:0]      crc;
    logic [31:0]      fcs_word;
    logic [7:0]       fcs_byte;
    logic             accept;

    assign s_ready = (state_q == StData);
    assign tx_busy = (state_q != StIdle);
    assign accept  = s_ready && s_valid;
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

    crc32_d8 u_crc (
        .clk_i  (gmii_tx_clk),
        .rst_i  (rst),
        .init_i (state_q == StIdle),
        .en_i   (accept || (state_q == StPad)),
        .data_i ((state_q == StPad) ? 8'h00 : s_data),
        .crc_o  (crc)
    );

    // An aborted frame sends the raw register so the receiver's FCS check fails.
    always_comb begin
        fcs_word = abort_q ? crc : ~crc;
        fcs_byte = fcs_word[7:0];
        case (cnt_q[1:0])
            2'd0:    fcs_byte = fcs_word[7:0];
            2'd1:    fcs_byte = fcs_word[15:8];
            2'd2:    fcs_byte = fcs_word[23:16];
            default: fcs_byte = fcs_word[31:24];
        endcase
    end

    always_ff @(posedge gmii_tx_clk) begin
        if (rst) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            gmii_tx_en <= 1'b0;
            gmii_txd   <= 8'h00;
            frame_done <= 1'b0;
            underrun   <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            underrun   <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    cnt_q      <= '0;
                    abort_q    <= 1'b0;
                    if (s_valid) state_q <= StPre;
                end
                StPre: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= PREAMBLE_BYTE;
                    if (cnt_q == CNT_W'(PREAMBLE_BYTES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StSfd;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StSfd: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= SFD_BYTE;
                    state_q    <= StData;
                end
                StData: begin
                    gmii_tx_en <= 1'b1;
                    if (s_valid) begin
                        gmii_txd <= s_data;
                        cnt_q    <= cnt_inc;
                        if (s_last) begin
`ifdef GMII_TX_PAD_EN
                            if (cnt_inc < CNT_W'(MIN_DATA_BYTES)) begin
                                state_q <= StPad;
                            end else begin
                                cnt_q   <= '0;
                                state_q <= StFcs;
                            end
`else
                            cnt_q   <= '0;
                            state_q <= StFcs;
`endif
                        end
                    end else begin
                        // Starved: first FCS byte goes out now so tx_en never drops mid-frame.
                        gmii_txd <= crc[7:0];
                        underrun <= 1'b1;
                        abort_q  <= 1'b1;
                        cnt_q    <= CNT_W'(1);
                        state_q  <= StFcs;
                    end
                end
                StPad: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= 8'h00;
                    if (cnt_inc >= CNT_W'(MIN_DATA_BYTES)) begin
                        cnt_q   <= '0;
                        state_q <= StFcs;
                    end else begin
                        cnt_q <= cnt_inc;
                    end
                end
                StFcs: begin
                    gmii_tx_en <= 1'b1;
                    gmii_txd   <= fcs_byte;
                    if (cnt_q[1:0] == 2'd3) begin
                        frame_done <= 1'b1;
                        cnt_q      <= '0;
                        state_q    <= StIfg;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StIfg: begin
                    gmii_tx_en <= 1'b0;
                    gmii_txd   <= 8'h00;
                    if (cnt_q == CNT_W'(IFG_BYTES - 1)) begin
                        cnt_q   <= '0;
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule
